// File: rtl/shared_ram_arb.sv
`default_nettype none
// +-------------------------------------------------------------------------------------+
// | shared_ram_arb : round-robin N-channel access to one word-addressed byte-write RAM, |
// |                  configurable ack latency, combinational debug read port.           |
// | Revision       : 1.0                                                                |
// +-------------------------------------------------------------------------------------+
module shared_ram_arb #(
    parameter int NCH        = 2,
    parameter int DW         = 32,
    parameter int AW         = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int RD_LAT     = 1,
    parameter     INIT_FILE  = ""
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NCH-1:0]         req,
    input  logic [NCH-1:0]         we,
    input  logic [NCH*(DW/8)-1:0]  be,
    input  logic [NCH*AW-1:0]      addr,
    input  logic [NCH*DW-1:0]      wdata,
    output logic [NCH-1:0]         ack,
    output logic [DW-1:0]          rdata,
    output logic                   busy,
    input  logic [AW-1:0]          dra,
    output logic [DW-1:0]          drd
);
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int IW    = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    logic [IW-1:0]         r_ptr;
    logic [IW-1:0]         r_id;
    logic [3:0]            r_cnt;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [NCH-1:0]        r_ack;
    logic [DW-1:0]         r_rdata;
    logic                  r_busy;
    logic [DW-1:0]         r_mem [DEPTH];

    logic [NB-1:0]         w_be_a   [NCH];
    logic [AW-1:0]         w_addr_a [NCH];
    logic [DW-1:0]         w_wd_a   [NCH];

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign w_be_a[k]   = be[k*NB +: NB];
        assign w_addr_a[k] = addr[k*AW +: AW];
        assign w_wd_a[k]   = wdata[k*DW +: DW];
    end

    // Round-robin pick: first requesting channel at or after r_ptr, wrapping.
    logic          w_any;
    logic [IW-1:0] w_win;
    logic [IW:0]   w_j;
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_j   = '0;
        for (int i = 0; i < NCH; i++) begin
            w_j = {1'b0, r_ptr} + (IW+1)'(i);
            if (w_j >= (IW+1)'(NCH)) w_j = w_j - (IW+1)'(NCH);
            if (!w_any && req[w_j[IW-1:0]]) begin
                w_any = 1'b1;
                w_win = w_j[IW-1:0];
            end
        end
    end

    logic [DEPTH_LOG2-1:0] w_idx;
    logic [NB-1:0]         w_be;
    logic [DW-1:0]         w_wd;
    logic                  w_wr;
    logic [DW-1:0]         w_merge;

    assign w_idx = w_addr_a[w_win][DEPTH_LOG2+1:2];
    assign w_be  = w_be_a[w_win];
    assign w_wd  = w_wd_a[w_win];
    assign w_wr  = (r_state == S_IDLE) && w_any && we[w_win];

    // Post-write word, needed when the response is captured on the same edge as the write.
    always_comb begin
        w_merge = r_mem[w_idx];
        if (we[w_win]) begin
            for (int b = 0; b < NB; b++) begin
                if (w_be[b]) w_merge[b*8 +: 8] = w_wd[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            for (int b = 0; b < NB; b++) begin
                if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wd[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_id    <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_ack   <= '0;
            r_rdata <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_ack <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_id   <= w_win;
                        r_idx  <= w_idx;
                        r_busy <= 1'b1;
                        if (RD_LAT == 1) begin
                            r_state <= S_RESP;
                            r_ack   <= NCH'(1) << w_win;
                            r_rdata <= w_merge;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= 4'(RD_LAT - 2);
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_RESP;
                        r_ack   <= NCH'(1) << r_id;
                        r_rdata <= r_mem[r_idx];
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_ptr   <= (r_id == IW'(NCH - 1)) ? '0 : r_id + 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ack   = r_ack;
    assign rdata = r_rdata;
    assign busy  = r_busy;
    assign drd   = r_mem[dra[DEPTH_LOG2+1:2]];

    // Address bits outside the word index are intentionally ignored (aliasing).
    logic w_unused;
    assign w_unused = ^{addr, dra};

endmodule
`default_nettype wire

// File: tb/tb_shared_ram_arb.sv
`default_nettype none
// tb_shared_ram_arb: two instances (latency 1 and 4) driven by per-channel requesters and
// compared against a transaction-level model of arbitration order, timing and memory.
module tb_shared_ram_arb;
  localparam int NCH  = 3;
  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int DL   = 10;
  localparam int NB   = DW / 8;
  localparam int LAT0 = 1;
  localparam int LAT1 = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  logic [NCH-1:0]    req   [2];
  logic [NCH-1:0]    we    [2];
  logic [NCH*NB-1:0] be    [2];
  logic [NCH*AW-1:0] addr  [2];
  logic [NCH*DW-1:0] wdata [2];
  logic [NCH-1:0]    ack   [2];
  logic [DW-1:0]     rdata [2];
  logic              busy  [2];
  logic [AW-1:0]     dra   [2];
  logic [DW-1:0]     drd   [2];

  shared_ram_arb #(.NCH(NCH), .DW(DW), .AW(AW), .DEPTH_LOG2(DL), .RD_LAT(LAT0), .INIT_FILE("")) u_dut0 (
    .clk(clk), .rstn(rstn), .req(req[0]), .we(we[0]), .be(be[0]), .addr(addr[0]),
    .wdata(wdata[0]), .ack(ack[0]), .rdata(rdata[0]), .busy(busy[0]), .dra(dra[0]), .drd(drd[0]));

  shared_ram_arb #(.NCH(NCH), .DW(DW), .AW(AW), .DEPTH_LOG2(DL), .RD_LAT(LAT1), .INIT_FILE("")) u_dut1 (
    .clk(clk), .rstn(rstn), .req(req[1]), .we(we[1]), .be(be[1]), .addr(addr[1]),
    .wdata(wdata[1]), .ack(ack[1]), .rdata(rdata[1]), .busy(busy[1]), .dra(dra[1]), .drd(drd[1]));

  // Reference model state
  logic [DW-1:0] mmem [2][1<<DL];
  int            m_ptr [2];
  int            m_next_idle [2];
  int            m_ack_cyc [2];
  int            m_ack_ch [2];
  logic [DW-1:0] m_rd [2];

  // Requester state per instance/channel
  bit            pend  [2][NCH];
  bit            p_we  [2][NCH];
  logic [NB-1:0] p_be  [2][NCH];
  logic [AW-1:0] p_addr[2][NCH];
  logic [DW-1:0] p_wd  [2][NCH];
  int            ack_at[2][NCH];
  logic [DW-1:0] ack_rd[2][NCH];

  int cyc    = 0;
  int n_vec  = 0;
  int n_err  = 0;
  bit rnd_en = 1'b0;
  bit dbg_en = 1'b0;

  function automatic int lat_of(int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  task automatic chk(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit any_pend();
    bit r = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < NCH; k++)
        if (pend[d][k]) r = 1'b1;
    return r;
  endfunction

  task automatic drive();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < NCH; k++) begin
        req[d][k] = pend[d][k];
        if (pend[d][k]) begin
          we[d][k]              = p_we[d][k];
          be[d][k*NB +: NB]     = p_be[d][k];
          addr[d][k*AW +: AW]   = p_addr[d][k];
          wdata[d][k*DW +: DW]  = p_wd[d][k];
        end else begin
          we[d][k]              = 1'($urandom);
          be[d][k*NB +: NB]     = NB'($urandom);
          addr[d][k*AW +: AW]   = $urandom;
          wdata[d][k*DW +: DW]  = $urandom;
        end
      end
    end
  endtask

  // Any cycle at or after m_next_idle is idle; a pending request there is accepted.
  task automatic accept(int d);
    int k;
    logic [DL-1:0] idx;
    if (cyc < m_next_idle[d]) return;
    k = -1;
    for (int i = 0; i < NCH; i++)
      if (k < 0 && pend[d][(m_ptr[d] + i) % NCH]) k = (m_ptr[d] + i) % NCH;
    if (k < 0) return;
    idx = p_addr[d][k][DL+1:2];
    if (p_we[d][k])
      for (int b = 0; b < NB; b++)
        if (p_be[d][k][b]) mmem[d][idx][8*b +: 8] = p_wd[d][k][8*b +: 8];
    m_rd[d]        = mmem[d][idx];
    m_ack_cyc[d]   = cyc + lat_of(d);
    m_ack_ch[d]    = k;
    m_next_idle[d] = cyc + lat_of(d) + 1;
    m_ptr[d]       = (k + 1) % NCH;
  endtask

  task automatic step();
    logic [NCH-1:0] ea;
    int widx;
    @(negedge clk);
    cyc++;
    widx = $urandom_range(0, 15);
    for (int d = 0; d < 2; d++) dra[d] = ($urandom & 32'hFFFF_F003) | (32'(widx) << 2);
    #1;
    for (int d = 0; d < 2; d++) begin
      ea = (cyc == m_ack_cyc[d]) ? (NCH'(1) << m_ack_ch[d]) : '0;
      chk($sformatf("ack%0d", d), DW'(ack[d]), DW'(ea));
      chk($sformatf("busy%0d", d), DW'(busy[d]), DW'(cyc < m_next_idle[d]));
      if (dbg_en) chk($sformatf("drd%0d", d), drd[d], mmem[d][widx]);
      if (ea != '0) begin
        chk($sformatf("rdata%0d", d), rdata[d], m_rd[d]);
        pend[d][m_ack_ch[d]]   = 1'b0;
        ack_at[d][m_ack_ch[d]] = cyc;
        ack_rd[d][m_ack_ch[d]] = rdata[d];
      end
    end
    if (rnd_en) begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < NCH; k++) begin
          if (!pend[d][k] && $urandom_range(0, 2) == 0) begin
            pend[d][k]   = 1'b1;
            p_we[d][k]   = 1'($urandom);
            p_be[d][k]   = NB'($urandom);
            p_addr[d][k] = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
            p_wd[d][k]   = $urandom;
          end
        end
      end
    end
    drive();
    accept(0);
    accept(1);
  endtask

  task automatic wait_done();
    int g = 0;
    while (any_pend() && g < 200) begin
      step();
      g++;
    end
    chk("drain", DW'(any_pend()), '0);
  endtask

  task automatic set_req(int k, bit w, logic [NB-1:0] b, logic [AW-1:0] a, logic [DW-1:0] wd);
    for (int d = 0; d < 2; d++) begin
      pend[d][k]   = 1'b1;
      p_we[d][k]   = w;
      p_be[d][k]   = b;
      p_addr[d][k] = a;
      p_wd[d][k]   = wd;
    end
  endtask

  task automatic txn(int k, bit w, logic [NB-1:0] b, logic [AW-1:0] a, logic [DW-1:0] wd);
    set_req(k, w, b, a, wd);
    wait_done();
  endtask

  task automatic do_reset();
    @(negedge clk);
    cyc++;
    rstn = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_ack%0d", d), DW'(ack[d]), '0);
      chk($sformatf("rst_busy%0d", d), DW'(busy[d]), '0);
      chk($sformatf("rst_rdata%0d", d), rdata[d], '0);
      for (int k = 0; k < NCH; k++) pend[d][k] = 1'b0;
      m_next_idle[d] = 0;
      m_ack_cyc[d]   = -1;
      m_ptr[d]       = 0;
    end
    drive();
    @(negedge clk);
    cyc++;
    rstn = 1'b1;
  endtask

  initial begin
    int iss;
    for (int d = 0; d < 2; d++) begin
      dra[d] = '0;
      for (int i = 0; i < (1 << DL); i++) mmem[d][i] = '0;
      for (int k = 0; k < NCH; k++) begin
        pend[d][k] = 1'b0; ack_at[d][k] = 0; ack_rd[d][k] = '0;
      end
    end
    drive();
    do_reset();

    // Contention from reset: ch0 before ch1, one access per latency+1 cycles
    set_req(0, 1'b1, 4'hF, 32'h40, 32'hDEADBEEF);
    set_req(1, 1'b1, 4'hF, 32'h80, 32'h11223344);
    iss = cyc + 1;
    wait_done();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("lat%0d", d), DW'(ack_at[d][0] - iss), DW'(lat_of(d)));
      chk($sformatf("order%0d", d), DW'(ack_at[d][0] < ack_at[d][1]), 32'd1);
      chk($sformatf("gap%0d", d), DW'(ack_at[d][1] - ack_at[d][0]), DW'(lat_of(d) + 1));
    end

    txn(0, 1'b0, 4'h0, 32'h40, 32'h0);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rd40_%0d", d), ack_rd[d][0], 32'hDEADBEEF);
      dra[d] = 32'h40;
    end
    #1;
    for (int d = 0; d < 2; d++) chk($sformatf("drd40_%0d", d), drd[d], 32'hDEADBEEF);

    // Byte enables, zero-enable write, address wrap-around
    txn(2, 1'b1, 4'b0101, 32'h80, 32'hAABBCCDD);
    txn(2, 1'b0, 4'h0, 32'h80, 32'h0);
    txn(1, 1'b1, 4'h0, 32'h40, 32'h0BAD0BAD);
    txn(1, 1'b0, 4'h0, 32'h40, 32'h0);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("be_%0d", d), ack_rd[d][2], 32'h11BB33DD);
      chk($sformatf("be0_%0d", d), ack_rd[d][1], 32'hDEADBEEF);
    end
    txn(1, 1'b1, 4'hF, 32'h1004, 32'h5);
    txn(2, 1'b0, 4'h0, 32'h0004, 32'h0);
    for (int d = 0; d < 2; d++) chk($sformatf("wrap_%0d", d), ack_rd[d][2], 32'h5);

    // A request arriving while busy waits until after the response
    set_req(0, 1'b0, 4'h0, 32'h40, 32'h0);
    iss = cyc + 1;
    step();
    set_req(2, 1'b0, 4'h0, 32'h80, 32'h0);
    wait_done();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("lat_b%0d", d), DW'(ack_at[d][0] - iss), DW'(lat_of(d)));
      chk($sformatf("wait_b%0d", d), DW'(ack_at[d][2] - ack_at[d][0]), DW'(lat_of(d) + 1));
    end

    // Fill a small word pool, then randomised traffic with debug reads enabled
    for (int i = 0; i < 16; i++) txn(i % NCH, 1'b1, 4'hF, 32'(i) << 2, 32'h5A5A0000 ^ (32'(i) * 32'h01030507));
    dbg_en = 1'b1;
    rnd_en = 1'b1;
    repeat (1500) step();
    rnd_en = 1'b0;
    wait_done();
    repeat (3) step();

    // Reset in the middle of a latency-4 access: no ack, committed write survives
    set_req(0, 1'b1, 4'hF, 32'h24, 32'hCAFEF00D);
    step();
    step();
    step();
    do_reset();
    repeat (6) step();
    set_req(2, 1'b0, 4'h0, 32'h24, 32'h0);
    set_req(0, 1'b0, 4'h0, 32'h24, 32'h0);
    wait_done();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_first%0d", d), DW'(ack_at[d][0] < ack_at[d][2]), 32'd1);
      chk($sformatf("rst_keep%0d", d), ack_rd[d][0], 32'hCAFEF00D);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
